// File: rtl/hazard_forward_unit.sv
// ID-stage hazard and forwarding controller: a three-stage destination scoreboard
// drives operand forward selects, a load-use stall and a saturating stall counter.
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_ID,
    input  logic [2:0]       Ra_ID,
    input  logic [2:0]       Rb_ID,
    input  logic             useA_ID,
    input  logic             useB_ID,
    input  logic [2:0]       Rd_ID,
    input  logic             RegWr_ID,
    input  logic             MemRd_ID,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    logic [2:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic             ex_wr_q, ex_wr_d, mem_wr_q, mem_wr_d, wb_wr_q, wb_wr_d;
    logic             ex_ld_q, ex_ld_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [1:0][2:0]  src;
    logic [1:0]       use_en;
    logic [1:0]       ex_hit, mem_hit, wb_hit;
    logic [1:0][1:0]  fwd_sel;

    assign src    = {Rb_ID, Ra_ID};
    assign use_en = {useB_ID, useA_ID};

    // Index 0 is operand A, index 1 is operand B; r0 never matches any stage.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign ex_hit[gi]  = use_en[gi] && (src[gi] != 3'd0) && ex_wr_q  && (ex_rd_q  == src[gi]);
            assign mem_hit[gi] = use_en[gi] && (src[gi] != 3'd0) && mem_wr_q && (mem_rd_q == src[gi]);
            assign wb_hit[gi]  = use_en[gi] && (src[gi] != 3'd0) && wb_wr_q  && (wb_rd_q  == src[gi]);
            assign fwd_sel[gi] = ex_hit[gi]  ? 2'd1 :
                                 mem_hit[gi] ? 2'd2 :
                                 wb_hit[gi]  ? 2'd3 : 2'd0;
        end
    endgenerate

    assign ForwardA    = fwd_sel[0];
    assign ForwardB    = fwd_sel[1];
    assign stall       = valid_ID && ex_ld_q && (ex_hit != 2'b00);
    assign stall_count = stall_count_q;

    always_comb begin
        wb_rd_d       = mem_rd_q;
        wb_wr_d       = mem_wr_q;
        mem_rd_d      = ex_rd_q;
        mem_wr_d      = ex_wr_q;
        ex_rd_d       = 3'd0;
        ex_wr_d       = 1'b0;
        ex_ld_d       = 1'b0;
        stall_count_d = stall_count_q;
        // A stalled or squashed ID instruction enters EX as a bubble.
        if (!stall) begin
            ex_rd_d = Rd_ID;
            ex_wr_d = RegWr_ID && valid_ID;
            ex_ld_d = MemRd_ID && valid_ID;
        end
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd_q       <= 3'd0;
            ex_wr_q       <= 1'b0;
            ex_ld_q       <= 1'b0;
            mem_rd_q      <= 3'd0;
            mem_wr_q      <= 1'b0;
            wb_rd_q       <= 3'd0;
            wb_wr_q       <= 1'b0;
            stall_count_q <= '0;
        end else begin
            ex_rd_q       <= ex_rd_d;
            ex_wr_q       <= ex_wr_d;
            ex_ld_q       <= ex_ld_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            wb_rd_q       <= wb_rd_d;
            wb_wr_q       <= wb_wr_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios plus randomized traffic against
// an instruction-history model; a second instance with CNT_W=2 covers saturation.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ID;
    logic [2:0]  Ra_ID, Rb_ID, Rd_ID;
    logic        useA_ID, useB_ID, RegWr_ID, MemRd_ID;
    logic [1:0]  ForwardA, ForwardB, fa_s, fb_s;
    logic        stall, stall_s;
    logic [15:0] stall_count;
    logic [1:0]  count_s;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .reset(reset), .valid_ID(valid_ID),
        .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .useA_ID(useA_ID), .useB_ID(useB_ID),
        .Rd_ID(Rd_ID), .RegWr_ID(RegWr_ID), .MemRd_ID(MemRd_ID),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .stall(stall), .stall_count(stall_count)
    );

    hazard_forward_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .valid_ID(valid_ID),
        .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .useA_ID(useA_ID), .useB_ID(useB_ID),
        .Rd_ID(Rd_ID), .RegWr_ID(RegWr_ID), .MemRd_ID(MemRd_ID),
        .ForwardA(fa_s), .ForwardB(fb_s), .stall(stall_s), .stall_count(count_s)
    );

    // Reference model: the last three instructions that entered EX, youngest first.
    typedef struct {
        int rd;
        bit wr;
        bit ld;
    } instr_t;
    instr_t hist[3];
    int     m_cnt;
    int     m_cnt_s;

    function automatic int m_fwd(int s, bit u);
        if (!u || s == 0) return 0;
        for (int a = 0; a < 3; a++)
            if (hist[a].wr && hist[a].rd == s) return a + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        return valid_ID && hist[0].ld && hist[0].wr &&
               (m_fwd(int'(Ra_ID), useA_ID) == 1 || m_fwd(int'(Rb_ID), useB_ID) == 1);
    endfunction

    task automatic set_id(input bit v, input int ra, input int rb, input bit ua, input bit ub,
                          input int rd, input bit wr, input bit ld);
        valid_ID = v;  Ra_ID = 3'(ra);  Rb_ID = 3'(rb);  useA_ID = ua;  useB_ID = ub;
        Rd_ID = 3'(rd);  RegWr_ID = wr;  MemRd_ID = ld;
        #3;
    endtask

    // Advance one clock and move the model with it.
    task automatic tick();
        bit s;
        @(posedge clk);
        s = m_stall();
        if (reset) begin
            for (int a = 0; a < 3; a++) hist[a] = '{0, 0, 0};
            m_cnt = 0;
            m_cnt_s = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (s) hist[0] = '{0, 0, 0};
            else   hist[0] = '{int'(Rd_ID), RegWr_ID && valid_ID, MemRd_ID && valid_ID};
            if (s && m_cnt < 65535) m_cnt++;
            if (s && m_cnt_s < 3)   m_cnt_s++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_id(1, 1, 0, 1, 0, 0, 0, 0);
        checks += 4;
        if (ForwardA !== 2'd0) begin fails++; $display("FAIL reset_fwdA: got %0d want 0", ForwardA); end
        if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall); end
        if (stall_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", stall_count); end
        if (count_s !== 2'd0) begin fails++; $display("FAIL reset_count_sat: got %0d want 0", count_s); end
        $display("test_reset: fwdA=%0d stall=%0b count=%0d", ForwardA, stall, stall_count);
    endtask

    task automatic test_alu_chain();
        int want[4] = '{1, 2, 3, 0};
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_id(1, 3, 0, 1, 0, 0, 0, 0);
            checks++;
            if (int'(ForwardA) != want[i] || $isunknown(ForwardA)) begin
                fails++; $display("FAIL alu_chain_age%0d: got %0d want %0d", i, ForwardA, want[i]);
            end
            $display("test_alu_chain: age=%0d fwdA=%0d", i, ForwardA);
            tick();
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) begin
            set_id(1, 0, 0, 0, 0, 2, 1, 0);
            tick();
        end
        set_id(1, 2, 2, 0, 1, 0, 0, 0);
        checks += 2;
        if (ForwardB !== 2'd1) begin fails++; $display("FAIL priority_fwdB: got %0d want 1", ForwardB); end
        if (ForwardA !== 2'd0) begin fails++; $display("FAIL priority_unusedA: got %0d want 0", ForwardA); end
        $display("test_priority: fwdA=%0d fwdB=%0d", ForwardA, ForwardB);
        tick();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 0, 0, 4, 1, 1);
        tick();
        set_id(1, 4, 0, 1, 0, 0, 0, 0);
        checks += 2;
        if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %0b want 1", stall); end
        if (ForwardA !== 2'd1) begin fails++; $display("FAIL load_use_fwd_during: got %0d want 1", ForwardA); end
        tick();
        set_id(1, 4, 0, 1, 0, 0, 0, 0);
        checks += 3;
        if (stall !== 1'b0) begin fails++; $display("FAIL load_use_restall: got %0b want 0", stall); end
        if (ForwardA !== 2'd2) begin fails++; $display("FAIL load_use_fwd_after: got %0d want 2", ForwardA); end
        if (stall_count !== 16'd1) begin fails++; $display("FAIL load_use_count: got %0d want 1", stall_count); end
        $display("test_load_use: fwdA=%0d stall=%0b count=%0d", ForwardA, stall, stall_count);
        tick();
    endtask

    task automatic test_r0_unused();
        set_id(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_id(1, 0, 0, 1, 0, 5, 1, 1);
        checks++;
        if (ForwardA !== 2'd0) begin fails++; $display("FAIL r0_fwdA: got %0d want 0", ForwardA); end
        tick();
        set_id(1, 0, 5, 0, 0, 0, 0, 0);
        checks += 2;
        if (stall !== 1'b0) begin fails++; $display("FAIL unusedB_stall: got %0b want 0", stall); end
        if (ForwardB !== 2'd0) begin fails++; $display("FAIL unusedB_fwd: got %0d want 0", ForwardB); end
        set_id(1, 0, 5, 0, 1, 0, 0, 0);
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL usedB_stall: got %0b want 1", stall); end
        $display("test_r0_unused: fwdA=%0d fwdB=%0d stall=%0b", ForwardA, ForwardB, stall);
        tick();
        tick();
    endtask

    task automatic test_squash_and_reset();
        int base;
        set_id(1, 0, 0, 0, 0, 6, 1, 1);
        tick();
        set_id(0, 6, 0, 1, 0, 0, 0, 0);
        checks += 2;
        if (stall !== 1'b0) begin fails++; $display("FAIL squash_stall: got %0b want 0", stall); end
        if (ForwardA !== 2'd1) begin fails++; $display("FAIL squash_fwd: got %0d want 1", ForwardA); end
        base = int'(stall_count);
        tick();
        set_id(1, 6, 0, 1, 0, 7, 1, 1);
        checks += 2;
        if (ForwardA !== 2'd2) begin fails++; $display("FAIL squash_bubble_fwd: got %0d want 2", ForwardA); end
        if (int'(stall_count) != base) begin fails++; $display("FAIL squash_count: got %0d want %0d", stall_count, base); end
        tick();
        set_id(1, 7, 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_id(1, 7, 0, 1, 0, 0, 0, 0);
        checks += 3;
        if (ForwardA !== 2'd0) begin fails++; $display("FAIL midstall_reset_fwd: got %0d want 0", ForwardA); end
        if (stall !== 1'b0) begin fails++; $display("FAIL midstall_reset_stall: got %0b want 0", stall); end
        if (stall_count !== 16'd0) begin fails++; $display("FAIL midstall_reset_count: got %0d want 0", stall_count); end
        $display("test_squash_and_reset: fwdA=%0d stall=%0b count=%0d", ForwardA, stall, stall_count);
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1));
            bad = 0;
            checks += 5;
            if (int'(ForwardA) != m_fwd(int'(Ra_ID), useA_ID) || $isunknown(ForwardA)) begin
                fails++; bad++; $display("FAIL rand_fwdA #%0d: got %0d want %0d", n, ForwardA, m_fwd(int'(Ra_ID), useA_ID));
            end
            if (int'(ForwardB) != m_fwd(int'(Rb_ID), useB_ID) || $isunknown(ForwardB)) begin
                fails++; bad++; $display("FAIL rand_fwdB #%0d: got %0d want %0d", n, ForwardB, m_fwd(int'(Rb_ID), useB_ID));
            end
            if (stall !== m_stall()) begin
                fails++; bad++; $display("FAIL rand_stall #%0d: got %0b want %0b", n, stall, m_stall());
            end
            if (int'(stall_count) != m_cnt || $isunknown(stall_count)) begin
                fails++; bad++; $display("FAIL rand_count #%0d: got %0d want %0d", n, stall_count, m_cnt);
            end
            if (int'(count_s) != m_cnt_s || $isunknown(count_s)) begin
                fails++; bad++; $display("FAIL rand_count_sat #%0d: got %0d want %0d", n, count_s, m_cnt_s);
            end
            $display("test_random #%0d: rst=%0b v=%0b Ra=%0d/%0b Rb=%0d/%0b -> fA=%0d fB=%0d st=%0b cnt=%0d errs=%0d",
                     n, reset, valid_ID, Ra_ID, useA_ID, Rb_ID, useB_ID, ForwardA, ForwardB, stall, stall_count, bad);
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            set_id(1, 0, 0, 0, 0, 1, 1, 1);
            tick();
            set_id(1, 1, 0, 1, 0, 0, 0, 0);
            tick();
            checks += 2;
            if (int'(stall_count) != i) begin fails++; $display("FAIL sat_count16 #%0d: got %0d want %0d", i, stall_count, i); end
            if (int'(count_s) != (i < 3 ? i : 3)) begin
                fails++; $display("FAIL sat_count2 #%0d: got %0d want %0d", i, count_s, (i < 3 ? i : 3));
            end
            $display("test_saturation #%0d: count16=%0d count2=%0d", i, stall_count, count_s);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int a = 0; a < 3; a++) hist[a] = '{0, 0, 0};
        m_cnt = 0;
        m_cnt_s = 0;
        test_reset();
        test_alu_chain();
        test_priority();
        test_load_use();
        test_r0_unused();
        test_squash_and_reset();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
